// File: rtl/uart_core_mc.sv
// Bus-mapped UART: TX/RX FIFOs, programmable frame format, 16x-oversampled RX, sticky errors.
// Optional macro UART_IRQ_EN adds the registered level interrupt and the CTRL irq enables.
module uart_core_mc_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the same clock pops.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module uart_core_mc #(
  parameter int FIFO_DEPTH    = 8,
  parameter int MAX_DATA_BITS = 8,
  parameter int BAUD_WIDTH    = 16,
  parameter int BAUD_RESET    = 650
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_bus_s_rd_en,
  input  logic        io_bus_s_wr_en,
  input  logic        io_bus_s_cs,
  input  logic [31:0] io_bus_s_address,
  input  logic [31:0] io_bus_s_wr_data,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq,
  output logic [31:0] rd_data
);
  localparam int DW = MAX_DATA_BITS;
  localparam int BW = BAUD_WIDTH;
  localparam logic [3:0] MAXB = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0] addr;
  logic       bus_rd, bus_wr, sel_data, sel_status, sel_baud, sel_ctrl;
  logic       unused_bits;
  assign addr        = io_bus_s_address[7:0];
  assign bus_rd      = io_bus_s_cs & io_bus_s_rd_en;
  assign bus_wr      = io_bus_s_cs & io_bus_s_wr_en;
  assign sel_data    = (addr == 8'h00);
  assign sel_status  = (addr == 8'h04);
  assign sel_baud    = (addr == 8'h08);
  assign sel_ctrl    = (addr == 8'h0C);
  assign unused_bits = ^{io_bus_s_address[31:8], io_bus_s_wr_data};

  // Control registers
  logic [BW-1:0] baud_r;
  logic [3:0]    data_bits;
  logic [1:0]    parity;
  logic          two_stop;
  logic [8:0]    ctrl_rd;
  logic [3:0]    db_in;
  assign db_in = io_bus_s_wr_data[3:0];

`ifdef UART_IRQ_EN
  logic rx_irq_en, tx_irq_en;
  assign ctrl_rd = {tx_irq_en, rx_irq_en, two_stop, parity, data_bits};
`else
  assign ctrl_rd = {2'b00, two_stop, parity, data_bits};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_r    <= BW'(BAUD_RESET);
      data_bits <= MAXB;
      parity    <= 2'd0;
      two_stop  <= 1'b0;
`ifdef UART_IRQ_EN
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
`endif
    end else if (bus_wr) begin
      if (sel_baud) baud_r <= io_bus_s_wr_data[BW-1:0];
      if (sel_ctrl) begin
        data_bits <= (db_in < 4'd5 || db_in > MAXB) ? MAXB : db_in;
        parity    <= io_bus_s_wr_data[5:4];
        two_stop  <= io_bus_s_wr_data[6];
`ifdef UART_IRQ_EN
        rx_irq_en <= io_bus_s_wr_data[7];
        tx_irq_en <= io_bus_s_wr_data[8];
`endif
      end
    end
  end

  // Shared baud tick: one pulse per BAUD+1 clocks, phase restarted by a BAUD write.
  logic [BW-1:0] baud_cnt;
  logic          tick;
  assign tick = (baud_cnt == BW'(1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    baud_cnt <= '0;
    else if (bus_wr && sel_baud)   baud_cnt <= '0;
    else if (baud_cnt >= baud_r)   baud_cnt <= '0;
    else                           baud_cnt <= baud_cnt + BW'(1);
  end

  // FIFOs
  logic          tx_pop, tx_empty, tx_full, tx_push;
  logic [DW-1:0] tx_dout;
  logic          rx_push, rx_pop, rx_empty, rx_full, rx_pop_eff;
  logic [DW-1:0] rx_dout, rx_push_dat;
  assign tx_push    = bus_wr & sel_data;
  assign rx_pop     = bus_rd & sel_data;
  assign rx_pop_eff = rx_pop & ~rx_empty;

  uart_core_mc_fifo #(.DEPTH(FIFO_DEPTH), .W(DW)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop),
    .din(io_bus_s_wr_data[DW-1:0]), .dout(tx_dout), .empty(tx_empty), .full(tx_full)
  );
  uart_core_mc_fifo #(.DEPTH(FIFO_DEPTH), .W(DW)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop),
    .din(rx_push_dat), .dout(rx_dout), .empty(rx_empty), .full(rx_full)
  );

  // TX engine
  state_t        tx_state;
  logic [3:0]    tx_tick, tx_bit, tx_nbits;
  logic [DW-1:0] tx_sh;
  logic [1:0]    tx_par;
  logic          tx_two, tx_stop2nd, tx_pacc, tx_busy;
  assign tx_busy = (tx_state != S_IDLE);
  // Next frame loads straight out of STOP so back-to-back frames have no idle gap.
  assign tx_pop = tick & ~tx_empty &
                  ((tx_state == S_IDLE) ||
                   (tx_state == S_STOP && tx_tick == 4'd15 && (!tx_two || tx_stop2nd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE; uart_tx <= 1'b1; tx_tick <= '0; tx_bit <= '0;
      tx_nbits <= MAXB; tx_sh <= '0; tx_par <= '0; tx_two <= 1'b0;
      tx_stop2nd <= 1'b0; tx_pacc <= 1'b0;
    end else if (tx_pop) begin
      tx_state <= S_START; uart_tx <= 1'b0; tx_tick <= '0;
      tx_sh <= tx_dout; tx_nbits <= data_bits; tx_par <= parity; tx_two <= two_stop;
    end else if (tick && tx_state != S_IDLE) begin
      tx_tick <= tx_tick + 4'd1;
      if (tx_tick == 4'd15) begin
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA; uart_tx <= tx_sh[0]; tx_pacc <= tx_sh[0];
            tx_sh <= tx_sh >> 1; tx_bit <= 4'd1;
          end
          S_DATA: begin
            if (tx_bit == tx_nbits) begin
              if (tx_par[0] ^ tx_par[1]) begin
                tx_state <= S_PARITY; uart_tx <= tx_pacc ^ (tx_par == 2'd2);
              end else begin
                tx_state <= S_STOP; uart_tx <= 1'b1; tx_stop2nd <= 1'b0;
              end
            end else begin
              uart_tx <= tx_sh[0]; tx_pacc <= tx_pacc ^ tx_sh[0];
              tx_sh <= tx_sh >> 1; tx_bit <= tx_bit + 4'd1;
            end
          end
          S_PARITY: begin
            tx_state <= S_STOP; uart_tx <= 1'b1; tx_stop2nd <= 1'b0;
          end
          S_STOP: begin
            if (tx_two && !tx_stop2nd) tx_stop2nd <= 1'b1;
            else                       tx_state   <= S_IDLE;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  // RX engine
  logic          rx_meta, rx_s, rx_prev;
  state_t        rx_state;
  logic [3:0]    rx_tick, rx_bit, rx_nbits;
  logic [DW-1:0] rx_sh;
  logic [1:0]    rx_par;
  logic          rx_pacc, rx_perr_pend, rx_set_ferr, rx_set_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1; rx_s <= 1'b1; rx_prev <= 1'b1;
      rx_state <= S_IDLE; rx_tick <= '0; rx_bit <= '0; rx_nbits <= MAXB;
      rx_sh <= '0; rx_par <= '0; rx_pacc <= 1'b0; rx_perr_pend <= 1'b0;
      rx_push <= 1'b0; rx_push_dat <= '0; rx_set_ferr <= 1'b0; rx_set_perr <= 1'b0;
    end else begin
      rx_meta     <= uart_rx;
      rx_s        <= rx_meta;
      rx_prev     <= rx_s;
      rx_push     <= 1'b0;
      rx_set_ferr <= 1'b0;
      rx_set_perr <= 1'b0;
      if (rx_state == S_IDLE) begin
        if (rx_prev && !rx_s) begin
          rx_state <= S_START; rx_tick <= '0; rx_bit <= '0; rx_sh <= '0;
          rx_pacc <= 1'b0; rx_perr_pend <= 1'b0;
          rx_nbits <= data_bits; rx_par <= parity;
        end
      end else if (tick) begin
        rx_tick <= rx_tick + 4'd1;
        case (rx_state)
          S_START: if (rx_tick == 4'd7) begin
            rx_tick  <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end
          S_DATA: if (rx_tick == 4'd15) begin
            rx_sh   <= rx_sh | (DW'(rx_s) << rx_bit);
            rx_pacc <= rx_pacc ^ rx_s;
            rx_bit  <= rx_bit + 4'd1;
            if (rx_bit == rx_nbits - 4'd1)
              rx_state <= (rx_par[0] ^ rx_par[1]) ? S_PARITY : S_STOP;
          end
          S_PARITY: if (rx_tick == 4'd15) begin
            rx_perr_pend <= rx_s ^ rx_pacc ^ (rx_par == 2'd2);
            rx_state     <= S_STOP;
          end
          S_STOP: if (rx_tick == 4'd15) begin
            rx_push     <= 1'b1;
            rx_push_dat <= rx_sh;
            rx_set_ferr <= ~rx_s;
            rx_set_perr <= rx_perr_pend;
            rx_state    <= S_IDLE;
          end
          default: rx_state <= S_IDLE;
        endcase
      end
    end
  end

  // Sticky error flags; a new error wins over a same-cycle W1C.
  logic       frame_err, parity_err, overrun, st_wr;
  logic [7:0] status;
  assign st_wr  = bus_wr & sel_status;
  assign status = {tx_busy, overrun, parity_err, frame_err, tx_full, tx_empty, rx_full, rx_empty};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0; parity_err <= 1'b0; overrun <= 1'b0;
    end else begin
      frame_err  <= (frame_err  & ~(st_wr & io_bus_s_wr_data[4])) | rx_set_ferr;
      parity_err <= (parity_err & ~(st_wr & io_bus_s_wr_data[5])) | rx_set_perr;
      overrun    <= (overrun    & ~(st_wr & io_bus_s_wr_data[6])) |
                    (rx_push & rx_full & ~rx_pop_eff);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (bus_rd) begin
      if (sel_data)        rd_data <= rx_empty ? 32'd0 : 32'(rx_dout);
      else if (sel_status) rd_data <= 32'(status);
      else if (sel_baud)   rd_data <= 32'(baud_r);
      else if (sel_ctrl)   rd_data <= 32'(ctrl_rd);
      else                 rd_data <= 32'd0;
    end
  end

`ifdef UART_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else irq <= (rx_irq_en & (~rx_empty | frame_err | parity_err | overrun)) |
                (tx_irq_en & tx_empty & ~tx_busy);
  end
`else
  assign irq = 1'b0;
`endif
endmodule

// File: doc/uart_core_mc.md
Name: uart_core_mc

Overview:
Parametrised next-generation UART peripheral on the IO interconnect slave bus. It has configurable FIFO depth and data width, programmable frame format (data bits, parity, stop bits) and 16x-oversampled RX. RX errors (frame/parity/overrun) are detected and held as sticky flags, and an optional interrupt is provided. Internal RX/TX serial engines and FIFOs are self-contained, and one shared baud-tick generator drives both.

Parameters:
FIFO_DEPTH, 8, entries per RX and TX FIFO; power of 2, minimum 2.
MAX_DATA_BITS, 8, maximum frame data width; FIFO width. Legal 5..9.
BAUD_WIDTH, 16, width of baud divisor register.
BAUD_RESET, 650, reset divisor; tick period = BAUD+1 clocks (16x oversample: 100 MHz at 9600 baud).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
io_bus_s_rd_en  input  1  bus read strobe
io_bus_s_wr_en  input  1  bus write strobe
io_bus_s_cs  input  1  chip select for this block
io_bus_s_address  input  32  byte address; only [7:0] decoded
io_bus_s_wr_data  input  32  write data
uart_rx  input  1  serial input, asynchronous to clk
uart_tx  output  1  serial output, idle high
irq  output  1  level interrupt (see Optional Feature)
rd_data  output  32  registered read data

Behaviour:
- Register map (address[7:0]); unused bits read 0; unmapped reads return 0:
  - 0x00 DATA. Write pushes wr_data[MAX_DATA_BITS-1:0] to TX FIFO; dropped silently if full. Read returns RX head and pops if non-empty; an empty read returns 0 and does not pop.
  - 0x04 STATUS. Bits: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] frame_err, [5] parity_err, [6] overrun, [7] tx_busy. Writing 1 to bits 4..6 clears them (W1C).
  - 0x08 BAUD [BAUD_WIDTH-1:0], RW.
  - 0x0C CTRL, RW. Fields: [3:0] data_bits (values outside 5..MAX_DATA_BITS are clamped to MAX_DATA_BITS), [5:4] parity (0 none, 1 even, 2 odd, 3 none), [6] two_stop, [7] rx_irq_en, [8] tx_irq_en. Reset value: data_bits=MAX_DATA_BITS, no parity, 1 stop, irqs off.
- Read latency: rd_data updates 1 clk after cs&rd_en; it holds its value otherwise. RX pop takes effect on the same edge.
- Reset values: uart_tx=1, irq=0, rd_data=0, FIFOs empty, flags 0, BAUD=BAUD_RESET, divisor counter 0, both FSMs IDLE.
- Baud tick: counter counts 0..BAUD and wraps; tick is a 1-clk pulse when counter==1. A BAUD write restarts the counter at 0.
- uart_rx is passed through a 2-flop synchroniser before use.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - Each bit lasts 16 ticks. Data is sent LSB first, data_bits bits.
  - In IDLE, if the FIFO is non-empty, pop on the next tick and enter START.
  - PARITY is skipped when parity is none. STOP lasts 1 or 2 bit times.
  - On STOP completion, go back to IDLE; back-to-back frames have no extra idle.
  - tx_busy = state!=IDLE.
  - CTRL/BAUD changes mid-frame take effect from the next frame only (frame format is latched at START).
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - A falling edge in IDLE enters START. At the 8th tick, a line reading 1 is a glitch and returns to IDLE.
  - Otherwise sample at mid-bit every 16 ticks. The data value is right-justified.
  - STOP samples one stop bit only. A stop bit of 0 sets frame_err and the byte is still pushed. A parity mismatch sets parity_err and the byte is still pushed.
  - A push to a full RX FIFO drops the byte and sets overrun.
  - Push and pop on the same clk with the FIFO full: both succeed.
- W1C clear coinciding with a new error set: set wins.
- FIFO push+pop simultaneously on an empty FIFO: push only; read data returns 0.

Optional Feature:
UART_IRQ_EN.
- Defined: irq is registered and computed as (rx_irq_en & (~rx_empty | frame_err | parity_err | overrun)) | (tx_irq_en & tx_empty & ~tx_busy).
- Not defined: irq is tied to 0, CTRL bits 7..8 read 0 and writes to them are ignored.

Test Plan:
1. Reset with BAUD=3, default CTRL. Write DATA=0xA5 -> uart_tx shows start 0, bits 1,0,1,0,0,1,0,1, stop 1. Each bit is 64 clks. tx_busy=1 during the frame, then tx_empty=1.
2. Loop uart_tx to uart_rx, with CTRL data_bits=7, even parity, two_stop. Write 0x55 then 0x2A -> RX reads 0x55, 0x2A, no error flags. Each frame is 11 bit times.
3. Drive RX frame 0x3C with a stop bit of 0 -> STATUS[4]=1, DATA=0x3C. Write STATUS=0x10 -> bit 4 clears.
4. Send 9 frames with no reads, FIFO_DEPTH=8 -> rx_full=1, overrun=1. Reads return the first 8 bytes, then rx_empty=1.
5. Drive a 2-clk low glitch on uart_rx while idle -> no push, no flags.
6. With UART_IRQ_EN and rx_irq_en=1: receive 1 byte -> irq=1. Read DATA -> irq=0 within 2 clks.
